// File: rtl/nu_residue_alu_pipe_pkg.sv
// Shared opcodes, flag patterns and mod 2^K-1 residue helpers for nu_residue_alu_pipe.
// The optional checker-injection port is enabled by NU_RESIDUE_INJECT_EN.
`ifndef NU_RESIDUE_ALU_PIPE_MACROS
`define NU_RESIDUE_ALU_PIPE_MACROS
`define SIZE_OPCODE_I   6
`define EXECUTION_FLAGS 6
`endif

package nu_residue_alu_pipe_pkg;

  localparam int RES_KMAX = 8;
  typedef logic [RES_KMAX-1:0] res_t;

  typedef enum logic [1:0] {CHK_NONE, CHK_ADD, CHK_SUB} chk_e;

  localparam logic [`SIZE_OPCODE_I-1:0] OP_NOP   = 6'd0;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_ADD   = 6'd1;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_ADDU  = 6'd2;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_ADDI  = 6'd3;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_ADDIU = 6'd4;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_SUB   = 6'd5;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_SUBU  = 6'd6;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_AND   = 6'd7;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_ANDI  = 6'd8;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_OR    = 6'd9;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_ORI   = 6'd10;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_XOR   = 6'd11;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_XORI  = 6'd12;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_NOR   = 6'd13;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_SLT   = 6'd14;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_SLTU  = 6'd15;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_SLTI  = 6'd16;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_SLTIU = 6'd17;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_SLL   = 6'd18;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_SRL   = 6'd19;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_SRA   = 6'd20;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_LUI   = 6'd21;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_MFHI  = 6'd22;
  localparam logic [`SIZE_OPCODE_I-1:0] OP_MTHI  = 6'd23;

  localparam logic [`EXECUTION_FLAGS-1:0] EXEC_OK  = 6'b010100;
  localparam logic [`EXECUTION_FLAGS-1:0] EXEC_NOP = 6'b000100;
  localparam logic [`EXECUTION_FLAGS-1:0] FLAG_OVF = 6'b000010;

  function automatic res_t res_modulus(input int k);
    return res_t'((9'd1 << k) - 9'd1);
  endfunction

  // 2^dw mod (2^k-1) collapses to 2^(dw mod k)
  function automatic res_t res_r(input int dw, input int k);
    return res_t'(9'd1 << (dw % k));
  endfunction

  function automatic res_t res_norm(input res_t x, input int k);
    return (x == res_modulus(k)) ? '0 : x;
  endfunction

  function automatic res_t eac_add(input res_t a, input res_t b, input int k);
    res_t              m;
    logic [RES_KMAX:0] s;
    logic [RES_KMAX:0] c;
    m = res_modulus(k);
    s = {1'b0, a & m} + {1'b0, b & m};
    c = s >> k;
    return ((s[RES_KMAX-1:0] & m) + res_t'(c[0])) & m;
  endfunction

endpackage

// File: rtl/nu_residue_alu_pipe_if.sv
// Issue/result bundle for nu_residue_alu_pipe; inject_i exists only with NU_RESIDUE_INJECT_EN.
interface nu_residue_alu_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 16,
  parameter int RES_K    = 5,
  parameter int ERRCNT_W = 16
);
  typedef logic [RES_K-1:0] inj_t;

  logic                          valid_i;
  logic [`SIZE_OPCODE_I-1:0]     opcode_i;
  logic [DATA_W-1:0]             data1_i;
  logic [DATA_W-1:0]             data2_i;
  logic [IMM_W-1:0]              immd_i;
  logic                          stall_i;
  logic                          clear_i;
`ifdef NU_RESIDUE_INJECT_EN
  inj_t                          inject_i;
`endif
  logic                          ready_o;
  logic                          valid_o;
  logic [DATA_W-1:0]             result_o;
  logic [`EXECUTION_FLAGS-1:0]   flags_o;
  logic                          error_o;
  logic [ERRCNT_W-1:0]           err_count_o;

  modport master (
`ifdef NU_RESIDUE_INJECT_EN
    output inject_i,
`endif
    output valid_i, opcode_i, data1_i, data2_i, immd_i, stall_i, clear_i,
    input  ready_o, valid_o, result_o, flags_o, error_o, err_count_o
  );

  modport slave (
`ifdef NU_RESIDUE_INJECT_EN
    input  inject_i,
`endif
    input  valid_i, opcode_i, data1_i, data2_i, immd_i, stall_i, clear_i,
    output ready_o, valid_o, result_o, flags_o, error_o, err_count_o
  );
endinterface

// File: rtl/nu_residue_alu_pipe_gen.sv
// Folds a DATA_W word into its mod 2^RES_K-1 residue with end-around-carry adds.
module nu_residue_gen
  import nu_residue_alu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RES_K  = 5
) (
  input  logic [DATA_W-1:0] i_data,
  output res_t              o_res
);
  localparam int NCH = (DATA_W + RES_K - 1) / RES_K;

  logic [NCH*RES_K-1:0] w_pad;
  res_t                 w_acc;

  always_comb begin
    w_pad = '0;
    w_pad[DATA_W-1:0] = i_data;
    w_acc = '0;
    for (int i = 0; i < NCH; i++)
      w_acc = eac_add(w_acc, res_t'(w_pad[i*RES_K +: RES_K]), RES_K);
    o_res = res_norm(w_acc, RES_K);
  end
endmodule

// File: rtl/nu_residue_alu_pipe.sv
// Two-stage ALU with mod 2^RES_K-1 residue checking of add/sub results.
// Define NU_RESIDUE_INJECT_EN to add inject_i, XORed into the S2 predicted residue.
module nu_residue_alu_pipe
  import nu_residue_alu_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 16,
  parameter int RES_K    = 5,
  parameter int ERRCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  nu_residue_alu_pipe_if.slave  bus
);
  localparam res_t RES_R = res_r(DATA_W, RES_K);
  localparam int   SHW   = $clog2(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0]           result;
    logic [`EXECUTION_FLAGS-1:0] flags;
    chk_e                        chk;
    logic                        carry;  // carry-out for add, borrow for sub
    res_t                        ra;
    res_t                        rb;
  } s1_t;

  logic [2:1]                  r_vld_pipe;
  s1_t                         r_s1;
  logic [DATA_W-1:0]           r_result;
  logic [`EXECUTION_FLAGS-1:0] r_flags;
  logic                        r_err;
  logic [ERRCNT_W-1:0]         r_cnt;

  s1_t               w_s1;
  logic              w_acc, w_fail;
  logic [DATA_W-1:0] w_a, w_d2, w_bs, w_sext, w_zext;
  logic [DATA_W:0]   w_sum, w_dif;
  logic [SHW-1:0]    w_sh;
  logic              w_is_imm_add;
  res_t              w_ra, w_rb, w_rres, w_pred, w_act;

  assign w_acc  = bus.valid_i & ~bus.stall_i;
  assign w_a    = bus.data1_i;
  assign w_d2   = bus.data2_i;
  assign w_sh   = bus.data2_i[SHW-1:0];
  assign w_sext = {{(DATA_W-IMM_W){bus.immd_i[IMM_W-1]}}, bus.immd_i};
  assign w_zext = {{(DATA_W-IMM_W){1'b0}}, bus.immd_i};
  assign w_is_imm_add = (bus.opcode_i == OP_ADDI) || (bus.opcode_i == OP_ADDIU);
  // B operand for the residue path: sign-extended immediate where the op uses it
  assign w_bs   = (w_is_imm_add || bus.opcode_i == OP_SLTI) ? w_sext : w_d2;
  assign w_sum  = {1'b0, w_a} + {1'b0, w_bs};
  assign w_dif  = {1'b0, w_a} - {1'b0, w_d2};

  nu_residue_gen #(.DATA_W(DATA_W), .RES_K(RES_K)) u_res_a (.i_data(w_a),         .o_res(w_ra));
  nu_residue_gen #(.DATA_W(DATA_W), .RES_K(RES_K)) u_res_b (.i_data(w_bs),        .o_res(w_rb));
  nu_residue_gen #(.DATA_W(DATA_W), .RES_K(RES_K)) u_res_r (.i_data(r_s1.result), .o_res(w_rres));

  always_comb begin
    w_s1       = '0;
    w_s1.ra    = w_ra;
    w_s1.rb    = w_rb;
    w_s1.flags = EXEC_OK;
    case (bus.opcode_i)
      OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: begin
        w_s1.result = w_sum[DATA_W-1:0];
        w_s1.carry  = w_sum[DATA_W];
        w_s1.chk    = CHK_ADD;
        if ((bus.opcode_i == OP_ADD || bus.opcode_i == OP_ADDI) &&
            (w_a[DATA_W-1] == w_bs[DATA_W-1]) && (w_sum[DATA_W-1] != w_a[DATA_W-1]))
          w_s1.flags = EXEC_OK | FLAG_OVF;
      end
      OP_SUB, OP_SUBU: begin
        w_s1.result = w_dif[DATA_W-1:0];
        w_s1.carry  = w_dif[DATA_W];
        w_s1.chk    = CHK_SUB;
        if ((bus.opcode_i == OP_SUB) &&
            (w_a[DATA_W-1] != w_d2[DATA_W-1]) && (w_dif[DATA_W-1] != w_a[DATA_W-1]))
          w_s1.flags = EXEC_OK | FLAG_OVF;
      end
      OP_AND:   w_s1.result = w_a & w_d2;
      OP_ANDI:  w_s1.result = w_a & w_zext;
      OP_OR:    w_s1.result = w_a | w_d2;
      OP_ORI:   w_s1.result = w_a | w_zext;
      OP_XOR:   w_s1.result = w_a ^ w_d2;
      OP_XORI:  w_s1.result = w_a ^ w_zext;
      OP_NOR:   w_s1.result = ~(w_a | w_d2);
      OP_SLT:   w_s1.result = {{(DATA_W-1){1'b0}}, $signed(w_a) < $signed(w_d2)};
      OP_SLTI:  w_s1.result = {{(DATA_W-1){1'b0}}, $signed(w_a) < $signed(w_sext)};
      OP_SLTU:  w_s1.result = {{(DATA_W-1){1'b0}}, w_a < w_d2};
      OP_SLTIU: w_s1.result = {{(DATA_W-1){1'b0}}, w_a < w_zext};
      OP_SLL:   w_s1.result = w_a << w_sh;
      OP_SRL:   w_s1.result = w_a >> w_sh;
      OP_SRA:   w_s1.result = DATA_W'($signed(w_a) >>> w_sh);
      OP_LUI:   w_s1.result = w_zext << (DATA_W - IMM_W);
      OP_MFHI, OP_MTHI: w_s1.result = w_a;
      OP_NOP:   w_s1.flags  = EXEC_NOP;
      default:  w_s1.flags  = '0;
    endcase
  end

  // Predicted side comes from operand residues, actual side from the result residue
  always_comb begin
    w_pred = '0;
    w_act  = '0;
    case (r_s1.chk)
      CHK_ADD: begin
        w_pred = eac_add(r_s1.ra, r_s1.rb, RES_K);
        w_act  = eac_add(w_rres, r_s1.carry ? RES_R : '0, RES_K);
      end
      CHK_SUB: begin
        w_pred = eac_add(r_s1.ra, r_s1.carry ? RES_R : '0, RES_K);
        w_act  = eac_add(w_rres, r_s1.rb, RES_K);
      end
      default: ;
    endcase
`ifdef NU_RESIDUE_INJECT_EN
    w_pred = w_pred ^ res_t'(bus.inject_i);
`endif
    w_fail = (r_s1.chk != CHK_NONE) && (res_norm(w_pred, RES_K) != res_norm(w_act, RES_K));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_result   <= '0;
      r_flags    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (!bus.stall_i) begin
        r_vld_pipe <= {r_vld_pipe[1], w_acc};
        if (w_acc) r_s1 <= w_s1;
        if (r_vld_pipe[1]) begin
          r_result <= r_s1.result;
          r_flags  <= r_s1.flags;
        end
      end
      if (bus.clear_i) begin
        r_err <= 1'b0;
        r_cnt <= '0;
      end else if (!bus.stall_i && r_vld_pipe[1] && w_fail) begin
        r_err <= 1'b1;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.ready_o     = ~bus.stall_i;
  assign bus.valid_o     = r_vld_pipe[2];
  assign bus.result_o    = r_result;
  assign bus.flags_o     = r_flags;
  assign bus.error_o     = r_err;
  assign bus.err_count_o = r_cnt;
endmodule

// File: tb/tb_nu_residue_alu_pipe.sv
// Scoreboarded random/directed bench for nu_residue_alu_pipe (DATA_W=32, RES_K=5).
module tb_nu_residue_alu_pipe;
  import nu_residue_alu_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nu_residue_alu_pipe_if #(.DATA_W(32), .IMM_W(16), .RES_K(5), .ERRCNT_W(16)) bus();

  nu_residue_alu_pipe #(.DATA_W(32), .IMM_W(16), .RES_K(5), .ERRCNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] r;
    logic [5:0]  f;
    logic        e;
    logic [15:0] c;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_err = 0;
  int          m_cnt = 0;
  logic [4:0]  m_inj = '0;
  bit          adv   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference behaviour straight from the op definitions, using wide signed math for overflow
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [15:0] imm, output logic [31:0] r,
                                output logic [5:0] f, output bit chkop);
    logic [31:0] se;
    logic [31:0] ze;
    longint      s;
    bit          ov;
    se = {{16{imm[15]}}, imm};
    ze = {16'h0, imm};
    r = 0; f = 6'h14; chkop = 0; ov = 0; s = 0;
    case (op)
      OP_ADD:   begin r = a + b;  s = longint'($signed(a)) + longint'($signed(b));  ov = 1; chkop = 1; end
      OP_ADDU:  begin r = a + b;  chkop = 1; end
      OP_ADDI:  begin r = a + se; s = longint'($signed(a)) + longint'($signed(se)); ov = 1; chkop = 1; end
      OP_ADDIU: begin r = a + se; chkop = 1; end
      OP_SUB:   begin r = a - b;  s = longint'($signed(a)) - longint'($signed(b));  ov = 1; chkop = 1; end
      OP_SUBU:  begin r = a - b;  chkop = 1; end
      OP_AND:   r = a & b;
      OP_ANDI:  r = a & ze;
      OP_OR:    r = a | b;
      OP_ORI:   r = a | ze;
      OP_XOR:   r = a ^ b;
      OP_XORI:  r = a ^ ze;
      OP_NOR:   r = ~(a | b);
      OP_SLT:   r = ($signed(a) < $signed(b))  ? 1 : 0;
      OP_SLTI:  r = ($signed(a) < $signed(se)) ? 1 : 0;
      OP_SLTU:  r = (a < b)  ? 1 : 0;
      OP_SLTIU: r = (a < ze) ? 1 : 0;
      OP_SLL:   r = a << b[4:0];
      OP_SRL:   r = a >> b[4:0];
      OP_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
      OP_LUI:   r = {imm, 16'h0};
      OP_MFHI, OP_MTHI: r = a;
      OP_NOP:   f = 6'h04;
      default:  f = 6'h00;
    endcase
    if (ov && (s > 64'sd2147483647 || s < -64'sd2147483648)) f[1] = 1'b1;
  endfunction

  // Drives one cycle of stimulus; called at posedge+1, returns at the next posedge+1
  task automatic drive(input bit v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input bit st);
    exp_t        e;
    bit          c;
    bus.valid_i  = v;
    bus.opcode_i = op;
    bus.data1_i  = a;
    bus.data2_i  = b;
    bus.immd_i   = imm;
    bus.stall_i  = st;
    if (v && !st) begin
      model(op, a, b, imm, e.r, e.f, c);
      if (c && m_inj != 0) begin
        m_err = 1;
        if (m_cnt < 65535) m_cnt++;
      end
      e.e = m_err;
      e.c = 16'(m_cnt);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, OP_NOP, 0, 0, 0, 0);
  endtask

  task automatic direct(input string nm, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] imm, input logic [31:0] er,
                        input bit eovf, input bit eerr);
    drive(1, op, a, b, imm, 0);
    chk({nm, "_lat1"}, bus.valid_o, 0);
    drive(0, OP_NOP, 0, 0, 0, 0);
    chk({nm, "_valid"}, bus.valid_o, 1);
    chk({nm, "_result"}, bus.result_o, er);
    chk({nm, "_ovf"}, bus.flags_o[1], eovf);
    chk({nm, "_error"}, bus.error_o, eerr);
    drive(0, OP_NOP, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) adv = !bus.stall_i;

  always @(negedge clk) begin
    if (reset && adv && bus.valid_o) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", bus.result_o, e.r);
        chk("flags", bus.flags_o, e.f);
        chk("error", bus.error_o, e.e);
        chk("errcnt", bus.err_count_o, e.c);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [5:0]  fa;
    bit          ca;
    reset = 1'b0;
    bus.valid_i = 0; bus.opcode_i = 0; bus.data1_i = 0; bus.data2_i = 0;
    bus.immd_i = 0; bus.stall_i = 0; bus.clear_i = 0;
`ifdef NU_RESIDUE_INJECT_EN
    bus.inject_i = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_result", bus.result_o, 0);
    chk("rst_flags", bus.flags_o, 0);
    chk("rst_error", bus.error_o, 0);
    chk("rst_errcnt", bus.err_count_o, 0);
    chk("rst_ready", bus.ready_o, 1);
    reset = 1'b1;
    idle(2);

    direct("addu_cout", OP_ADDU, 32'hFFFFFFFF, 32'h2, 0, 32'h1, 0, 0);
    direct("sub_borrow", OP_SUB, 32'h5, 32'h7, 0, 32'hFFFFFFFE, 0, 0);
    direct("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1, 0);
    direct("sub_ovf", OP_SUB, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 1, 0);
    direct("addi_neg", OP_ADDI, 32'h10, 0, 16'hFFFF, 32'hF, 0, 0);
    direct("sltiu_zext", OP_SLTIU, 32'h10, 0, 16'hFFFF, 32'h1, 0, 0);

    // four ops with a three-cycle stall between the second and third
    model(OP_ADD, 32'd100, 32'd23, 0, ra, fa, ca);
    drive(1, OP_ADD, 32'd100, 32'd23, 0, 0);
    drive(1, OP_XOR, 32'hF0F0, 32'h0FF0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_SUB, 32'd9, 32'd4, 0, 1);
      chk("stall_ready", bus.ready_o, 0);
      chk("stall_hold_valid", bus.valid_o, 1);
      chk("stall_hold_result", bus.result_o, ra);
    end
    bus.stall_i = 0;
    drive(1, OP_SUB, 32'd9, 32'd4, 0, 0);
    drive(1, OP_LUI, 0, 0, 16'hABCD, 0);
    idle(3);

    // random mix with backpressure, including unknown opcodes
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom % 8 == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 23));
      drive($urandom % 4 != 0, op, rnd32(), rnd32(), 16'($urandom), $urandom % 4 == 0);
    end
    idle(3);

    // reset asserted mid-stream must drop valid_o without waiting for a clock
    drive(1, OP_ADDU, 32'd1, 32'd2, 0, 0);
    drive(1, OP_ADDU, 32'd3, 32'd4, 0, 0);
    chk("pre_reset_valid", bus.valid_o, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_valid", bus.valid_o, 0);
    chk("async_reset_result", bus.result_o, 0);
    q.delete();
    m_err = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

`ifdef NU_RESIDUE_INJECT_EN
    bus.inject_i = 5'h1; m_inj = 5'h1;
    direct("inject_addi", OP_ADDI, 32'h10, 0, 16'hFFFF, 32'hF, 0, 1);
    chk("inject_cnt", bus.err_count_o, 1);
    bus.inject_i = '0; m_inj = '0;
    bus.clear_i = 1;
    idle(1);
    bus.clear_i = 0;
    m_err = 0; m_cnt = 0;
    chk("clear_error", bus.error_o, 0);
    chk("clear_cnt", bus.err_count_o, 0);
    bus.inject_i = 5'h1; m_inj = 5'h1;
    for (int i = 0; i < 65538; i++) drive(1, OP_ADDU, $urandom, $urandom, 0, 0);
    idle(3);
    chk("sat_cnt", bus.err_count_o, 16'hFFFF);
    chk("sat_error", bus.error_o, 1);
    bus.inject_i = '0; m_inj = '0;
    bus.clear_i = 1;
    idle(1);
    bus.clear_i = 0;
    m_err = 0; m_cnt = 0;
`endif

    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nu_residue_alu_pipe.md
Name: nu_residue_alu_pipe

Overview:
- Two-stage pipelined, parametrised integer ALU with residue-code (mod 2^K-1) checking of its arithmetic path.
- Generalises the single-cycle mod-31 ALU: configurable data width, immediate width and residue modulus.
- Adds valid/stall pipelining, carry/borrow-correct residue prediction, a sticky error flag and a saturating error counter.
- Sits in the execute lane in place of the simple ALU; its outputs feed writeback and the fault monitor.

Parameters:
- DATA_W, 32, operand/result width.
- IMM_W, 16, immediate width; sign/zero extension is to DATA_W.
- RES_K, 5, residue modulus M = 2^RES_K-1; legal range 2..8.
- ERRCNT_W, 16, error counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_i  in  1  issue valid.
- opcode_i  in  `SIZE_OPCODE_I  opcode, codebase macros.
- data1_i  in  DATA_W  operand A.
- data2_i  in  DATA_W  operand B.
- immd_i  in  IMM_W  immediate.
- stall_i  in  1  downstream backpressure; freezes both stages.
- clear_i  in  1  clears error_o and err_count_o.
- ready_o  out  1  = ~stall_i.
- valid_o  out  1  result valid.
- result_o  out  DATA_W  result.
- flags_o  out  `EXECUTION_FLAGS  execution flags.
- error_o  out  1  sticky residue-mismatch flag.
- err_count_o  out  ERRCNT_W  saturating mismatch count.

Behaviour:
- Reset (reset=0, asynchronous): all stage valids=0, result_o=0, flags_o=0, error_o=0, err_count_o=0.
- Latency: 2 cycles from accepted issue (valid_i & ready_o) to valid_o. Throughput is 1 per cycle when not stalled.
- stall_i=1: S1 and S2 hold their contents and no issue is accepted. valid_o and result_o hold their values. Counter and error updates occur only on S2 advance.
- S1 captures:
  - the ALU result and the DATA_W carry-out / borrow;
  - residues rA = |a|_M and rB = |b|_M, where b is data2_i, or the sign-extended immediate for ADDI/ADDIU and SLTI.
- Residue arithmetic: end-around-carry adds. 0 and all-ones both encode zero; comparisons normalise all-ones to 0. R = |2^DATA_W|_M is a compile-time constant.
- S2 check, performed only for ADD/ADDU/ADDI/ADDIU/SUB/SUBU:
  - add: |rA+rB|_M == |result|_M + cout·R;
  - sub: |result + rB|_M == |rA + borrow·R|_M, with borrow = (a <u b).
- A check failure while S2 advances with valid sets error_o=1 and increments err_count_o, saturating at all-ones. The failure is reported alongside the same valid_o beat.
- Logical, shift, SLT*, LUI, MF/MT ops: no check. Results are as in the simple ALU: ANDI/ORI/XORI/SLTIU zero-extend the immediate; SLT/SLTI compare signed.
- Flags, 6 bits:
  - executed ops: bits[4] and [2] set;
  - bit[1] = signed overflow, for ADD/ADDI/SUB only;
  - NOP: only bit[2] set;
  - unknown opcode: flags=0, result=0, valid still propagates.
- clear_i=1 clears error_o and err_count_o on the next edge. If clear_i coincides with a failure, clear wins and the failure is dropped.
- Stalled entries do not recount a failure.

Optional Feature:
- Macro: NU_RESIDUE_INJECT_EN.
- Defined: adds input port inject_i [RES_K-1:0]. It is XORed into the S2 predicted residue for the entry advancing that cycle, forcing a mismatch for checker verification.
- Undefined: no port and no XOR; the predicted residue is used unmodified.

Decomposition:
- Shared package / header (alongside opcode macros):
  - modulus constant and R computation function;
  - residue-normalise function;
  - flag-pattern constants EXEC_OK, EXEC_NOP.
- One sub-module, nu_residue_gen (parametrised DATA_W/RES_K), instanced for rA, rB and the result residue.
- The end-around-carry adder is a package function.

Test Plan (RES_K=5, M=31, R=4, DATA_W=32):
- ADDU 0xFFFFFFFF+0x2 -> result 0x1, cout=1, error_o=0. Check: rA=3, rB=2, 5 == 1+4.
- SUB 0x5-0x7 -> result 0xFFFFFFFE, borrow=1, error_o=0. Bit[1]=0 (no signed overflow).
- ADD 0x7FFFFFFF+0x1 -> result 0x80000000, flags bit[1]=1, error_o=0.
- Issue 4 back-to-back ops with stall_i high for 3 cycles mid-stream -> outputs in order, each exactly once; valid_o appears 2 unstalled cycles after issue.
- With NU_RESIDUE_INJECT_EN, ADDI 0x10+imm 0xFFFF with inject_i=5'h1 -> result 0xF, error_o=1, err_count_o=1. clear_i pulse -> both 0. Assert reset mid-stream -> valid_o=0 immediately.
- Force 2^16+2 injected failures -> err_count_o saturates at 0xFFFF.
